// File: rtl/core_pkg.sv
// Shared encodings for the load/store path: funct3 store sizes
// and the store sequencer FSM states.
package core_pkg;

    localparam logic [2:0] FU3_SB = 3'd0;
    localparam logic [2:0] FU3_SH = 3'd1;
    localparam logic [2:0] FU3_SW = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } st_state_e;

    function automatic logic fu3_legal(input logic [2:0] fu3);
        return (fu3 == FU3_SB) || (fu3 == FU3_SH) || (fu3 == FU3_SW);
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Positions store data and byte enables across two adjacent words
// according to the access size and the byte offset.
module store_lane_align
    import core_pkg::*;
(
    input  logic [2:0]  fu3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [7:0]  byte_en,
    output logic [63:0] data
);

    logic [3:0] mask;

    always_comb begin
        mask = 4'b0000;
        case (fu3)
            FU3_SB:  mask = 4'b0001;
            FU3_SH:  mask = 4'b0011;
            FU3_SW:  mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        byte_en = {4'b0000, mask} << addr_lo;
        data    = {32'b0, wdata} << {addr_lo, 3'b000};
    end

endmodule

// File: rtl/store_sequencer.sv
// Splits a possibly misaligned store into one or two word-aligned
// memory beats and reports completion or an illegal size.
module store_sequencer
    import core_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [2:0]        st_fu3,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_wdata,
    output logic              st_done,
    output logic              st_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_byte_en,
    input  logic              mem_ack
);

    st_state_e         state_q, state_d;
    logic [2:0]        fu3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        en;
    logic [63:0]       data;
    logic              split;
    logic [ADDR_W-1:0] beat0_addr;
    logic [ADDR_W-1:0] beat1_addr;

    store_lane_align u_align (
        .fu3     (fu3_q),
        .addr_lo (addr_q[1:0]),
        .wdata   (wdata_q),
        .byte_en (en),
        .data    (data)
    );

    assign split      = |en[7:4];
    assign beat0_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign beat1_addr = beat0_addr + ADDR_W'(4);
    assign st_done    = done_q;
    assign st_err     = err_q;

    always_comb begin
        state_d     = state_q;
        st_ready    = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_byte_en = 4'b0000;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                st_ready = 1'b1;
                if (st_valid) begin
                    if (fu3_legal(st_fu3)) state_d = ST_BEAT0;
                    else                   err_d   = 1'b1;
                end
            end
            ST_BEAT0: begin
                mem_req     = 1'b1;
                mem_addr    = beat0_addr;
                mem_wdata   = data[31:0];
                mem_byte_en = en[3:0];
                if (mem_ack) begin
                    state_d = split ? ST_BEAT1 : ST_IDLE;
                    done_d  = !split;
                end
            end
            ST_BEAT1: begin
                mem_req     = 1'b1;
                mem_addr    = beat1_addr;
                mem_wdata   = data[63:32];
                mem_byte_en = en[7:4];
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            fu3_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (st_valid && state_q == ST_IDLE) begin
                fu3_q   <= st_fu3;
                addr_q  <= st_addr;
                wdata_q <= st_wdata;
            end
        end
    end

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer: aligned, misaligned, split,
// stalled, wrapping, illegal and mid-operation reset scenarios.
module tb_store_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  st_fu3;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic        st_done;
    logic        st_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_ack;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    store_sequencer #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_fu3      (st_fu3),
        .st_addr     (st_addr),
        .st_wdata    (st_wdata),
        .st_done     (st_done),
        .st_err      (st_err),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_byte_en (mem_byte_en),
        .mem_ack     (mem_ack)
    );

    // Presents one request for exactly one accepting edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic ack);
        st_valid = 1'b1;
        st_fu3   = f;
        st_addr  = a;
        st_wdata = d;
        mem_ack  = ack;
        @(posedge clk);
        #1;
        st_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_fu3   = 3'd0;
        st_addr  = '0;
        st_wdata = '0;
        mem_ack  = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({st_ready, st_done, st_err, mem_req} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 1000",
                     {st_ready, st_done, st_err, mem_req});
        end
        vectors++;
        if ({mem_addr, mem_wdata, mem_byte_en} !== 68'd0) begin
            errors++;
            $display("FAIL reset_mem got %h/%h/%b want 0",
                     mem_addr, mem_wdata, mem_byte_en);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sw_aligned;
        issue(3'd2, 32'h100, 32'hAABBCCDD, 1'b1);
        @(negedge clk);
        vectors++;
        if ({mem_req, st_ready, mem_addr, mem_byte_en, mem_wdata} !==
            {1'b1, 1'b0, 32'h100, 4'b1111, 32'hAABBCCDD}) begin
            errors++;
            $display("FAIL sw_beat got req=%b rdy=%b %h/%b/%h want 1 0 100/1111/aabbccdd",
                     mem_req, st_ready, mem_addr, mem_byte_en, mem_wdata);
        end
        @(negedge clk);
        vectors++;
        if ({st_done, mem_req, st_ready} !== 3'b101) begin
            errors++;
            $display("FAIL sw_done got %b want 101", {st_done, mem_req, st_ready});
        end
        @(negedge clk);
        vectors++;
        if (st_done !== 1'b0) begin
            errors++;
            $display("FAIL sw_done_pulse got %b want 0", st_done);
        end
    endtask

    task automatic test_sb_offset;
        issue(3'd0, 32'h103, 32'h000000EE, 1'b1);
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_addr, mem_byte_en, mem_wdata} !==
            {1'b1, 32'h100, 4'b1000, 32'hEE000000}) begin
            errors++;
            $display("FAIL sb_beat got %b %h/%b/%h want 1 100/1000/ee000000",
                     mem_req, mem_addr, mem_byte_en, mem_wdata);
        end
        @(negedge clk);
        vectors++;
        if (st_done !== 1'b1) begin
            errors++;
            $display("FAIL sb_done got %b want 1", st_done);
        end
    endtask

    task automatic test_sh_split;
        issue(3'd1, 32'h203, 32'h00001234, 1'b1);
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_addr, mem_byte_en, mem_wdata} !==
            {1'b1, 32'h200, 4'b1000, 32'h34000000}) begin
            errors++;
            $display("FAIL sh_beat0 got %b %h/%b/%h want 1 200/1000/34000000",
                     mem_req, mem_addr, mem_byte_en, mem_wdata);
        end
        @(negedge clk);
        vectors++;
        if ({st_done, mem_req, mem_addr, mem_byte_en, mem_wdata} !==
            {1'b0, 1'b1, 32'h204, 4'b0001, 32'h00000012}) begin
            errors++;
            $display("FAIL sh_beat1 got done=%b %b %h/%b/%h want 0 1 204/0001/00000012",
                     st_done, mem_req, mem_addr, mem_byte_en, mem_wdata);
        end
        @(negedge clk);
        vectors++;
        if ({st_done, mem_req} !== 2'b10) begin
            errors++;
            $display("FAIL sh_done got %b want 10", {st_done, mem_req});
        end
        @(negedge clk);
        vectors++;
        if (st_done !== 1'b0) begin
            errors++;
            $display("FAIL sh_done_pulse got %b want 0", st_done);
        end
    endtask

    task automatic test_stall;
        issue(3'd2, 32'h101, 32'h11223344, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({st_ready, st_done, mem_req, mem_addr, mem_byte_en, mem_wdata} !==
                {1'b0, 1'b0, 1'b1, 32'h100, 4'b1110, 32'h22334400}) begin
                errors++;
                $display("FAIL stall_beat0[%0d] got rdy=%b done=%b %b %h/%b/%h want 0 0 1 100/1110/22334400",
                         i, st_ready, st_done, mem_req, mem_addr, mem_byte_en, mem_wdata);
            end
        end
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({st_ready, st_done, mem_req, mem_addr, mem_byte_en, mem_wdata} !==
                {1'b0, 1'b0, 1'b1, 32'h104, 4'b0001, 32'h00000011}) begin
                errors++;
                $display("FAIL stall_beat1[%0d] got rdy=%b done=%b %b %h/%b/%h want 0 0 1 104/0001/00000011",
                         i, st_ready, st_done, mem_req, mem_addr, mem_byte_en, mem_wdata);
            end
        end
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if ({st_done, st_ready, mem_req} !== 3'b110) begin
            errors++;
            $display("FAIL stall_done got %b want 110", {st_done, st_ready, mem_req});
        end
    endtask

    task automatic test_wrap;
        issue(3'd1, 32'hFFFFFFFF, 32'h0000BEEF, 1'b1);
        @(negedge clk);
        vectors++;
        if ({mem_addr, mem_byte_en, mem_wdata} !==
            {32'hFFFFFFFC, 4'b1000, 32'hEF000000}) begin
            errors++;
            $display("FAIL wrap_beat0 got %h/%b/%h want fffffffc/1000/ef000000",
                     mem_addr, mem_byte_en, mem_wdata);
        end
        @(negedge clk);
        vectors++;
        if ({mem_addr, mem_byte_en, mem_wdata} !==
            {32'h00000000, 4'b0001, 32'h000000BE}) begin
            errors++;
            $display("FAIL wrap_beat1 got %h/%b/%h want 00000000/0001/000000be",
                     mem_addr, mem_byte_en, mem_wdata);
        end
        @(negedge clk);
        vectors++;
        if (st_done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done got %b want 1", st_done);
        end
    endtask

    task automatic test_illegal;
        issue(3'd5, 32'h300, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        vectors++;
        if ({st_err, mem_req, st_ready, st_done} !== 4'b1010) begin
            errors++;
            $display("FAIL illegal_err got %b want 1010",
                     {st_err, mem_req, st_ready, st_done});
        end
        @(negedge clk);
        vectors++;
        if ({st_err, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL illegal_pulse got %b want 00", {st_err, mem_req});
        end
    endtask

    task automatic test_reset_mid;
        issue(3'd1, 32'h203, 32'h00005678, 1'b0);
        @(negedge clk);
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_addr, mem_byte_en} !== {1'b1, 32'h204, 4'b0001}) begin
            errors++;
            $display("FAIL rst_mid_beat1 got %b %h/%b want 1 204/0001",
                     mem_req, mem_addr, mem_byte_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({mem_req, st_ready, st_done, mem_addr, mem_byte_en} !==
            {1'b0, 1'b1, 1'b0, 32'h0, 4'b0000}) begin
            errors++;
            $display("FAIL rst_mid_async got req=%b rdy=%b done=%b %h/%b want 0 1 0 0/0000",
                     mem_req, st_ready, st_done, mem_addr, mem_byte_en);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if ({st_done, mem_req, st_ready} !== 3'b001) begin
                errors++;
                $display("FAIL rst_mid_after[%0d] got %b want 001",
                         i, {st_done, mem_req, st_ready});
            end
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset;
        test_sw_aligned;
        test_sb_offset;
        test_sh_split;
        test_stall;
        test_wrap;
        test_illegal;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/store_sequencer.md
STORE_SEQUENCER -- requirements
Module: store_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port st_valid, input, 1, store request from pipeline.
REQ-005 SHALL have port st_ready, output, 1, sequencer can accept a request.
REQ-006 SHALL have port st_fu3, input, 3, funct3: 0=sb, 1=sh, 2=sw.
REQ-007 SHALL have port st_addr, input, ADDR_W, byte address.
REQ-008 SHALL have port st_wdata, input, 32, store data, LSB-aligned.
REQ-009 SHALL have port st_done, output, 1, one-cycle pulse when the store fully completes.
REQ-010 SHALL have port st_err, output, 1, one-cycle pulse when a request has an illegal funct3.
REQ-011 SHALL have port mem_req, output, 1, memory write request.
REQ-012 SHALL have port mem_addr, output, ADDR_W, word-aligned address (bits [1:0]=0).
REQ-013 SHALL have port mem_wdata, output, 32, lane-positioned write data.
REQ-014 SHALL have port mem_byte_en, output, 4, byte-lane write enables.
REQ-015 SHALL have port mem_ack, input, 1, memory accepted the current beat.

Function
REQ-016 SHALL implement FSM states IDLE, BEAT0, BEAT1.
REQ-017 SHALL drive st_ready=1 only in IDLE.
REQ-018 SHALL accept a request when st_valid and st_ready; it SHALL latch fu3, addr and wdata at that edge.
REQ-019 SHALL treat funct3 values 3..7 as illegal: no memory beat, st_err=1 on the following cycle, and the FSM stays in IDLE.
REQ-020 SHALL form the size mask as sb=0001, sh=0011, sw=1111, and the 8-bit enable as mask << addr[1:0].
REQ-021 SHALL form 64-bit data as {32'b0,wdata} << (8*addr[1:0]); beat0 uses bits [31:0] and beat1 uses bits [63:32].
REQ-022 SHALL take beat0 byte_en from enable bits [3:0] and beat1 byte_en from bits [7:4]; the store is split when bits [7:4] are non-zero.
REQ-023 SHALL on a legal accept go IDLE->BEAT0 at the next edge.
REQ-024 SHALL in BEAT0 drive mem_req=1, mem_addr={addr[ADDR_W-1:2],2'b00}, beat0 data and enables.
REQ-025 SHALL on mem_ack in BEAT0 go to BEAT1 if split, else to IDLE with st_done=1 for one cycle after that edge.
REQ-026 SHALL in BEAT1 drive mem_req=1, mem_addr=beat0 address+4 (mod 2^ADDR_W, wrapping at the top), beat1 data and enables.
REQ-027 SHALL on mem_ack in BEAT1 go to IDLE with st_done=1 for one cycle.
REQ-028 SHALL hold mem_req, mem_addr, mem_wdata and mem_byte_en stable while mem_ack=0.
REQ-029 SHALL drive mem_req=0, mem_byte_en=0000 and mem_wdata=0 in IDLE.
REQ-030 SHALL ignore mem_ack outside BEAT0/BEAT1.
REQ-031 SHALL have a minimum latency of 2 cycles from accept to st_done for an unsplit store with same-cycle ack, and 3 cycles for a split store.

Reset
REQ-032 SHALL on rst_n=0 immediately force IDLE, with st_ready=1, st_done=0, st_err=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_byte_en=0, and latched request registers cleared.
REQ-033 SHALL abandon any in-flight beat on reset mid-operation, with no st_done for it.

Structure
REQ-034 SHALL place the funct3 encodings (SB/SH/SW) and FSM state encodings in a shared package (core_pkg).
REQ-035 SHALL use one sub-module, store_lane_align, as a pure combinational block: fu3 and addr[1:0] to 8-bit enable, and wdata to 64-bit shifted data.

Verification
REQ-036 sw to 0x100 with data 0xAABBCCDD and immediate ack SHALL produce one beat: addr 0x100, be 1111, data 0xAABBCCDD, then st_done.
REQ-037 sb to 0x103 with data 0x000000EE SHALL produce one beat: addr 0x100, be 1000, data 0xEE000000.
REQ-038 sh to 0x203 with data 0x00001234 SHALL produce two beats: 0x200/be 1000/data 0x34000000, then 0x204/be 0001/data 0x00000012, then one st_done.
REQ-039 sw to 0x101 with mem_ack held low 3 cycles per beat SHALL keep outputs stable during the wait, produce beats 0x100/be 1110 and 0x104/be 0001, and keep st_ready=0 throughout.
REQ-040 A request with fu3=5 SHALL produce an st_err pulse and no mem_req; rst_n low during BEAT1 SHALL drop mem_req immediately, produce no st_done, and leave st_ready=1.
